// File: rtl/multi_control_sequencer_n.sv
`default_nettype none
// ============================================================================
// Module   : multi_control_sequencer_n
// Brief    : N-channel power/enable sequencer. Brings ctrl[0..N_CH-1] up in
//            order, each stage gated by its ack, with per-stage timeout,
//            bounded full-sequence retries, reverse-order shutdown and a
//            latched fault with the offending channel number.
// Revision : 1.0 - initial release
// ============================================================================
module multi_control_sequencer_n #(
    parameter int N_CH      = 3,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic                                  fault_clr,
    input  logic [N_CH-1:0]                       ack,
    output logic [N_CH-1:0]                       ctrl,
    output logic                                  normal_start,
    output logic                                  busy,
    output logic                                  fault,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] fault_ch,
    output logic [2:0]                            retry_cnt
);

    localparam int c_CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_TW  = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_STAGE = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_SHDN  = 3'd3;
    localparam logic [2:0] c_ST_FAULT = 3'd4;

    // What to do once shutdown has cleared ctrl[0]
    localparam logic [1:0] c_PD_IDLE  = 2'd0;
    localparam logic [1:0] c_PD_RETRY = 2'd1;
    localparam logic [1:0] c_PD_FAULT = 2'd2;

    localparam logic [c_CHW-1:0] c_IDX_LAST = c_CHW'(N_CH - 1);
    localparam logic [c_TW-1:0]  c_TMO      = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0]  c_TMAX     = '1;
    localparam logic [2:0]       c_RMAX     = 3'(MAX_RETRY);

    logic [2:0]       r_state, w_state_nxt;
    logic [c_CHW-1:0] r_idx, w_idx_nxt;
    logic [1:0]       r_pend, w_pend_nxt;
    logic [c_TW-1:0]  r_timer, w_timer_nxt;
    logic             r_start_q;
    logic [2:0]       w_retry_nxt;
    logic [c_CHW-1:0] w_fault_ch_nxt;
    logic [N_CH-1:0]  w_ctrl_nxt;
    logic             w_busy_nxt, w_fault_nxt, w_normal_nxt;

    logic             w_start_rise, w_ack_k;
    logic             w_drop_any, w_low_any;
    logic [c_CHW-1:0] w_drop_ch, w_low_ch;

    assign w_start_rise = start & ~r_start_q;
    assign w_ack_k      = ack[r_idx];

    // Lowest low ack overall (RUN check) and lowest low ack below current stage
    always_comb begin
        w_drop_any = 1'b0;
        w_drop_ch  = '0;
        w_low_any  = 1'b0;
        w_low_ch   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (!ack[j]) begin
                w_low_any = 1'b1;
                w_low_ch  = c_CHW'(j);
                if (j < int'(r_idx)) begin
                    w_drop_any = 1'b1;
                    w_drop_ch  = c_CHW'(j);
                end
            end
        end
    end

    // State register plus registered outputs taken from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= '0;
            r_pend       <= c_PD_IDLE;
            r_timer      <= '0;
            r_start_q    <= 1'b0;
            retry_cnt    <= 3'd0;
            fault_ch     <= '0;
            ctrl         <= '0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            normal_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pend       <= w_pend_nxt;
            r_timer      <= w_timer_nxt;
            r_start_q    <= start;
            retry_cnt    <= w_retry_nxt;
            fault_ch     <= w_fault_ch_nxt;
            ctrl         <= w_ctrl_nxt;
            busy         <= w_busy_nxt;
            fault        <= w_fault_nxt;
            normal_start <= w_normal_nxt;
        end
    end

    // Next-state decode; priority ack-drop > timeout > stop > ack advance
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_pend_nxt     = r_pend;
        w_timer_nxt    = r_timer;
        w_retry_nxt    = retry_cnt;
        w_fault_ch_nxt = fault_ch;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = c_ST_STAGE;
                    w_idx_nxt   = '0;
                    w_timer_nxt = '0;
                    w_retry_nxt = 3'd0;
                end
            end
            c_ST_STAGE: begin
                if (w_drop_any) begin
                    w_state_nxt    = c_ST_FAULT;
                    w_fault_ch_nxt = w_drop_ch;
                end else if (!w_ack_k && (r_timer == c_TMO)) begin
                    w_state_nxt    = c_ST_SHDN;
                    w_fault_ch_nxt = r_idx;
                    if (retry_cnt < c_RMAX) begin
                        w_retry_nxt = retry_cnt + 3'd1;
                        w_pend_nxt  = c_PD_RETRY;
                    end else begin
                        w_pend_nxt  = c_PD_FAULT;
                    end
                end else if (stop) begin
                    w_state_nxt = c_ST_SHDN;
                    w_pend_nxt  = c_PD_IDLE;
                end else if (w_ack_k) begin
                    w_timer_nxt = '0;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else if (r_timer != c_TMAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            c_ST_RUN: begin
                if (w_low_any) begin
                    w_state_nxt    = c_ST_FAULT;
                    w_fault_ch_nxt = w_low_ch;
                end else if (stop) begin
                    w_state_nxt = c_ST_SHDN;
                    w_idx_nxt   = c_IDX_LAST;
                    w_pend_nxt  = c_PD_IDLE;
                end
            end
            c_ST_SHDN: begin
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - 1'b1;
                end else begin
                    case (r_pend)
                        c_PD_RETRY: begin
                            w_state_nxt = c_ST_STAGE;
                            w_timer_nxt = '0;
                        end
                        c_PD_FAULT: w_state_nxt = c_ST_FAULT;
                        default:    w_state_nxt = c_ST_IDLE;
                    endcase
                end
            end
            c_ST_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt    = c_ST_IDLE;
                    w_fault_ch_nxt = '0;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode from the next state so outputs line up with the state change
    always_comb begin
        w_ctrl_nxt   = '0;
        w_busy_nxt   = 1'b0;
        w_fault_nxt  = 1'b0;
        w_normal_nxt = 1'b0;
        case (w_state_nxt)
            c_ST_STAGE: begin
                w_busy_nxt = 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    w_ctrl_nxt[i] = (i <= int'(w_idx_nxt));
                end
            end
            c_ST_RUN: begin
                w_busy_nxt   = 1'b1;
                w_normal_nxt = 1'b1;
                w_ctrl_nxt   = '1;
            end
            c_ST_SHDN: begin
                w_busy_nxt = 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    w_ctrl_nxt[i] = (i < int'(w_idx_nxt));
                end
            end
            c_ST_FAULT: w_fault_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_control_sequencer_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_control_sequencer_n
// Brief    : Directed bench for multi_control_sequencer_n (N_CH=3,
//            TIMEOUT=8, MAX_RETRY=2) with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_control_sequencer_n;

    logic       clk = 1'b0;
    logic       rst, start, stop, fault_clr;
    logic [2:0] ack;
    logic [2:0] ctrl;
    logic       normal_start, busy, fault;
    logic [1:0] fault_ch;
    logic [2:0] retry_cnt;

    int n_total  = 0;
    int n_passed = 0;

    multi_control_sequencer_n #(
        .N_CH(3), .TIMEOUT(8), .MAX_RETRY(2)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .fault_clr(fault_clr),
        .ack(ack), .ctrl(ctrl), .normal_start(normal_start), .busy(busy),
        .fault(fault), .fault_ch(fault_ch), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; sample/drive 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // From IDLE with fresh start edge, ack following ctrl, up to RUN
    task automatic bring_up(input string tag);
        start = 1'b0; ack = 3'b000; tick();
        start = 1'b1; tick();
        ack = 3'b001; tick();
        ack = 3'b011; tick();
        ack = 3'b111; tick();
        check({tag, "_run_ns"}, normal_start, 1);
        check({tag, "_run_ctrl"}, ctrl, 3'b111);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; fault_clr = 1'b0; ack = 3'b000;
        tick(); tick();
        rst = 1'b0;
        check("rst_ctrl", ctrl, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_ns", normal_start, 0);
        check("rst_fch", fault_ch, 0);
        check("rst_retry", retry_cnt, 0);

        // 1: ack follows ctrl by two cycles
        start = 1'b1; tick();
        check("t1_ctrl0", ctrl, 3'b001);
        check("t1_busy", busy, 1);
        tick();
        check("t1_hold0", ctrl, 3'b001);
        ack = 3'b001; tick();
        check("t1_ctrl1", ctrl, 3'b011);
        tick();
        ack = 3'b011; tick();
        check("t1_ctrl2", ctrl, 3'b111);
        tick();
        check("t1_ns_early", normal_start, 0);
        ack = 3'b111; tick();
        check("t1_ns", normal_start, 1);
        check("t1_fault", fault, 0);
        check("t1_retry", retry_cnt, 0);

        // 4: orderly stop from RUN
        stop = 1'b1; tick();
        check("t4_s2", ctrl, 3'b011);
        check("t4_ns", normal_start, 0);
        tick();
        check("t4_s1", ctrl, 3'b001);
        tick();
        check("t4_s0", ctrl, 3'b000);
        check("t4_busy_s0", busy, 1);
        tick();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_fault", fault, 0);
        stop = 1'b0; tick();
        check("t4_no_restart", busy, 0);

        // 3: one-cycle ack[2] drop in RUN
        bring_up("t3");
        ack = 3'b011; tick();
        ack = 3'b111;
        check("t3_ctrl", ctrl, 3'b000);
        check("t3_fault", fault, 1);
        check("t3_fch", fault_ch, 2);
        check("t3_ns", normal_start, 0);
        check("t3_busy", busy, 0);
        tick();
        check("t3_fault_held", fault, 1);
        fault_clr = 1'b1; tick();
        fault_clr = 1'b0;
        check("t3_clr_fault", fault, 0);
        check("t3_clr_fch", fault_ch, 0);
        tick(); tick();
        check("t3_no_restart_busy", busy, 0);
        check("t3_no_restart_ctrl", ctrl, 0);

        // 5: ack[0] drop and stop in the same RUN cycle
        bring_up("t5");
        ack = 3'b110; stop = 1'b1; tick();
        ack = 3'b111; stop = 1'b0;
        check("t5_fault", fault, 1);
        check("t5_fch", fault_ch, 0);
        check("t5_ctrl", ctrl, 0);
        fault_clr = 1'b1; tick();
        fault_clr = 1'b0;
        check("t5_clr", fault, 0);

        // 2: ack[1] never rises -> two retries then fault
        start = 1'b0; ack = 3'b001; tick();
        start = 1'b1; tick();
        check("t2_stage0", ctrl, 3'b001);
        tick();
        for (int r = 0; r < 3; r++) begin
            check($sformatf("t2_r%0d_stage1", r), ctrl, 3'b011);
            repeat (7) tick();
            check($sformatf("t2_r%0d_before_tmo", r), ctrl, 3'b011);
            tick();
            check($sformatf("t2_r%0d_shdn1", r), ctrl, 3'b001);
            check($sformatf("t2_r%0d_retry", r), retry_cnt, (r < 2) ? r + 1 : 2);
            check($sformatf("t2_r%0d_nofault", r), fault, 0);
            tick();
            check($sformatf("t2_r%0d_shdn0", r), ctrl, 3'b000);
            if (r < 2) begin
                tick();
                check($sformatf("t2_r%0d_restart", r), ctrl, 3'b001);
                tick();
            end
        end
        tick();
        check("t2_fault", fault, 1);
        check("t2_fch", fault_ch, 1);
        check("t2_retry", retry_cnt, 2);
        check("t2_ctrl", ctrl, 0);
        check("t2_busy", busy, 0);
        fault_clr = 1'b1; tick();
        fault_clr = 1'b0;

        // 6: reset during STAGE(1)
        start = 1'b0; ack = 3'b000; tick();
        start = 1'b1; tick();
        check("t6_stage0", ctrl, 3'b001);
        check("t6_retry0", retry_cnt, 0);
        ack = 3'b001; tick();
        check("t6_stage1", ctrl, 3'b011);
        rst = 1'b1; start = 1'b0; tick();
        rst = 1'b0; ack = 3'b000;
        check("t6_rst_ctrl", ctrl, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fault", fault, 0);
        check("t6_rst_fch", fault_ch, 0);
        check("t6_rst_retry", retry_cnt, 0);
        check("t6_rst_ns", normal_start, 0);
        tick();
        start = 1'b1; tick();
        check("t6_restart", ctrl, 3'b001);
        check("t6_restart_busy", busy, 1);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
